// File: rtl/edit_mem_read_data_pkg.sv
// Shared widths, FSM state and output FIFO entry for the edit-memory read path.
package edit_mem_read_data_pkg;

    localparam int unsigned EM_BUF_PTR_NBITS = 10;
    localparam int unsigned PU_ID_NBITS      = 4;
    localparam int unsigned DATA_PATH_NBITS  = 32;
    localparam int unsigned PD_CHUNK_NBITS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2
    } rd_state_e;

    // One chunk as queued towards the downstream consumer.
    typedef struct packed {
        logic                       sop;
        logic                       eop;
        logic [PU_ID_NBITS-1:0]     port_id;
        logic [DATA_PATH_NBITS-1:0] data;
    } out_entry_t;

    localparam int unsigned OUT_ENTRY_NBITS = $bits(out_entry_t);

endpackage

// File: rtl/edit_mem_read_data_fifo.sv
// First-word-fall-through synchronous FIFO.
//   din/wr    : push side (push ignored when full)
//   dout/rd   : head entry, popped on rd (pop ignored when empty)
//   empty     : no entry held
//   count     : number of entries held (0..2^DEPTH_NBITS)
module sfifo2f_fo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH_NBITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr,
    input  logic                   rd,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [DEPTH_NBITS:0]   count
);

    localparam int unsigned DEPTH    = 1 << DEPTH_NBITS;
    localparam int unsigned CNT_BITS = DEPTH_NBITS + 1;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH_NBITS-1:0] wr_ptr_q;
    logic [DEPTH_NBITS-1:0] rd_ptr_q;
    logic [CNT_BITS-1:0]    count_q;
    logic                   full_c;
    logic                   push_c;
    logic                   pop_c;

    assign full_c = (count_q == CNT_BITS'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rd_ptr_q];
    assign push_c = wr & ~full_c;
    assign pop_c  = rd & ~empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + DEPTH_NBITS'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_NBITS'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/edit_mem_read_data.sv
// Edit-memory read path: walks a packet's buffer linked list, streams the
// chunks downstream, returns every visited buffer and reports completion.
//   rd_req_*          : packet descriptor (ptr, chunk count, PU id, discard)
//   mem_rd_*          : edit-memory read port (data/link 1 cycle after strobe)
//   em_tx_*           : chunk stream with sop/eop, valid/ready
//   em_buf_free_*     : buffer returned to the free pool
//   rd_done_*         : one pulse per descriptor
module edit_mem_read_data
    import edit_mem_read_data_pkg::*;
#(
    parameter int unsigned BPTR_NBITS           = EM_BUF_PTR_NBITS,
    parameter int unsigned ID_NBITS             = PU_ID_NBITS,
    parameter int unsigned DATA_NBITS           = DATA_PATH_NBITS,
    parameter int unsigned LEN_NBITS            = PD_CHUNK_NBITS,
    parameter int unsigned OUT_FIFO_DEPTH_NBITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [BPTR_NBITS-1:0] rd_req_buf_ptr,
    input  logic [LEN_NBITS-1:0]  rd_req_len,
    input  logic [ID_NBITS-1:0]   rd_req_port_id,
    input  logic                  rd_req_discard,
    output logic                  mem_rd_en,
    output logic [BPTR_NBITS-1:0] mem_rd_ptr,
    input  logic [DATA_NBITS-1:0] mem_rd_data,
    input  logic [BPTR_NBITS-1:0] mem_rd_nxt_ptr,
    output logic                  em_tx_valid,
    input  logic                  em_tx_ready,
    output logic                  em_tx_sop,
    output logic                  em_tx_eop,
    output logic [DATA_NBITS-1:0] em_tx_data,
    output logic [ID_NBITS-1:0]   em_tx_port_id,
    output logic                  em_buf_free_valid,
    output logic [BPTR_NBITS-1:0] em_buf_free_ptr,
    output logic                  rd_done_valid,
    output logic [ID_NBITS-1:0]   rd_done_port_id
);

    localparam int unsigned FIFO_DEPTH = 1 << OUT_FIFO_DEPTH_NBITS;
    localparam int unsigned CNT_NBITS  = OUT_FIFO_DEPTH_NBITS + 1;

    rd_state_e             state_q;
    logic [BPTR_NBITS-1:0] cur_ptr_q;
    logic [LEN_NBITS-1:0]  remaining_q;
    logic [ID_NBITS-1:0]   port_q;
    logic                  discard_q;
    logic                  first_q;
    logic                  free_valid_q;
    logic [BPTR_NBITS-1:0] free_ptr_q;
    logic                  done_valid_q;
    logic [ID_NBITS-1:0]   done_port_q;

    logic                  issue_c;
    logic                  fifo_push_c;
    logic                  fifo_pop_c;
    logic                  fifo_empty;
    logic [CNT_NBITS-1:0]  fifo_count;
    out_entry_t            push_entry_c;
    out_entry_t            pop_entry;

    // A non-discard read needs a guaranteed FIFO slot; only one read is ever
    // in flight and it is pushed before RD is re-evaluated, so count is exact.
    assign issue_c      = (state_q == ST_RD) &&
                          (discard_q || (fifo_count < CNT_NBITS'(FIFO_DEPTH)));
    assign rd_req_ready = (state_q == ST_IDLE);
    assign mem_rd_en    = issue_c;
    assign mem_rd_ptr   = cur_ptr_q;
    assign fifo_push_c  = (state_q == ST_WAIT) && !discard_q;
    assign fifo_pop_c   = em_tx_valid & em_tx_ready;

    // Chunk entry built from the memory response sampled in WAIT
    always_comb begin
        push_entry_c         = '0;
        push_entry_c.sop     = first_q;
        push_entry_c.eop     = (remaining_q == LEN_NBITS'(1));
        push_entry_c.port_id = PU_ID_NBITS'(port_q);
        push_entry_c.data    = DATA_PATH_NBITS'(mem_rd_data);
    end

    sfifo2f_fo #(
        .WIDTH       (OUT_ENTRY_NBITS),
        .DEPTH_NBITS (OUT_FIFO_DEPTH_NBITS)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (push_entry_c),
        .wr    (fifo_push_c),
        .rd    (fifo_pop_c),
        .dout  (pop_entry),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign em_tx_valid   = ~fifo_empty;
    assign em_tx_sop     = pop_entry.sop;
    assign em_tx_eop     = pop_entry.eop;
    assign em_tx_data    = DATA_NBITS'(pop_entry.data);
    assign em_tx_port_id = ID_NBITS'(pop_entry.port_id);

    assign em_buf_free_valid = free_valid_q;
    assign em_buf_free_ptr   = free_ptr_q;
    assign rd_done_valid     = done_valid_q;
    assign rd_done_port_id   = done_port_q;

    // Descriptor walk FSM with registered free/done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_ptr_q    <= '0;
            remaining_q  <= '0;
            port_q       <= '0;
            discard_q    <= 1'b0;
            first_q      <= 1'b0;
            free_valid_q <= 1'b0;
            free_ptr_q   <= '0;
            done_valid_q <= 1'b0;
            done_port_q  <= '0;
        end else begin
            free_valid_q <= 1'b0;
            done_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_req_valid) begin
                        cur_ptr_q   <= rd_req_buf_ptr;
                        remaining_q <= rd_req_len;
                        port_q      <= rd_req_port_id;
                        discard_q   <= rd_req_discard;
                        first_q     <= 1'b1;
                        if (rd_req_len != '0) begin
                            state_q <= ST_RD;
                        end else begin
                            // Empty packet: report completion, touch nothing
                            done_valid_q <= 1'b1;
                            done_port_q  <= rd_req_port_id;
                        end
                    end
                end
                ST_RD: begin
                    if (issue_c) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    free_valid_q <= 1'b1;
                    free_ptr_q   <= cur_ptr_q;
                    cur_ptr_q    <= mem_rd_nxt_ptr;
                    first_q      <= 1'b0;
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - LEN_NBITS'(1);
                    end
                    if (remaining_q == LEN_NBITS'(1)) begin
                        state_q      <= ST_IDLE;
                        done_valid_q <= 1'b1;
                        done_port_q  <= port_q;
                    end else begin
                        state_q <= ST_RD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edit_mem_read_data.sv
module tb_edit_mem_read_data;
    import edit_mem_read_data_pkg::*;

    localparam int unsigned BW     = EM_BUF_PTR_NBITS;
    localparam int unsigned IW     = PU_ID_NBITS;
    localparam int unsigned DW     = DATA_PATH_NBITS;
    localparam int unsigned LW     = PD_CHUNK_NBITS;
    localparam int unsigned MEM_N  = 1 << BW;
    localparam int unsigned BEAT_W = 2 + IW + DW;

    logic          clk;
    logic          rst;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [BW-1:0] rd_req_buf_ptr;
    logic [LW-1:0] rd_req_len;
    logic [IW-1:0] rd_req_port_id;
    logic          rd_req_discard;
    logic          mem_rd_en;
    logic [BW-1:0] mem_rd_ptr;
    logic [DW-1:0] mem_rd_data;
    logic [BW-1:0] mem_rd_nxt_ptr;
    logic          em_tx_valid;
    logic          em_tx_ready;
    logic          em_tx_sop;
    logic          em_tx_eop;
    logic [DW-1:0] em_tx_data;
    logic [IW-1:0] em_tx_port_id;
    logic          em_buf_free_valid;
    logic [BW-1:0] em_buf_free_ptr;
    logic          rd_done_valid;
    logic [IW-1:0] rd_done_port_id;

    edit_mem_read_data dut (
        .clk               (clk),
        .rst               (rst),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_buf_ptr    (rd_req_buf_ptr),
        .rd_req_len        (rd_req_len),
        .rd_req_port_id    (rd_req_port_id),
        .rd_req_discard    (rd_req_discard),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_ptr        (mem_rd_ptr),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_nxt_ptr    (mem_rd_nxt_ptr),
        .em_tx_valid       (em_tx_valid),
        .em_tx_ready       (em_tx_ready),
        .em_tx_sop         (em_tx_sop),
        .em_tx_eop         (em_tx_eop),
        .em_tx_data        (em_tx_data),
        .em_tx_port_id     (em_tx_port_id),
        .em_buf_free_valid (em_buf_free_valid),
        .em_buf_free_ptr   (em_buf_free_ptr),
        .rd_done_valid     (rd_done_valid),
        .rd_done_port_id   (rd_done_port_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [IW-1:0] port;
        logic [DW-1:0] data;
    } beat_t;

    int tests = 0;
    int fails = 0;
    int n_reads = 0;
    int n_frees = 0;
    int n_dones = 0;
    int n_beats = 0;
    int rdy_mode = 1;

    logic [DW-1:0] mdata [MEM_N];
    logic [BW-1:0] mnxt  [MEM_N];

    // Reference: what the packet walk must produce, computed at submit time
    logic [BW-1:0] exp_rd[$];
    logic [BW-1:0] exp_free[$];
    beat_t         exp_beat[$];
    logic [IW-1:0] exp_done[$];
    int            frees_left[$];

    logic              stall_q;
    logic [BEAT_W-1:0] hold_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edit memory: answers a strobe with the chunk data and link field
    always @(negedge clk) begin
        if (!rst && mem_rd_en) begin
            mem_rd_data    = mdata[mem_rd_ptr];
            mem_rd_nxt_ptr = mnxt[mem_rd_ptr];
        end
    end

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = random
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      em_tx_ready = 1'b0;
        else if (rdy_mode == 1) em_tx_ready = 1'b1;
        else                    em_tx_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare process: every observable event against the reference queues
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (mem_rd_en) begin
                n_reads++;
                if (exp_rd.size() == 0) chk("unexpected_read", 64'(mem_rd_ptr), 64'hFFFF_FFFF);
                else chk("rd_ptr", 64'(mem_rd_ptr), 64'(exp_rd.pop_front()));
            end
            if (em_buf_free_valid) begin
                n_frees++;
                if (exp_free.size() == 0) chk("unexpected_free", 64'(em_buf_free_ptr), 64'hFFFF_FFFF);
                else chk("free_ptr", 64'(em_buf_free_ptr), 64'(exp_free.pop_front()));
                if (frees_left.size() != 0) frees_left[0] = frees_left[0] - 1;
            end
            if (rd_done_valid) begin
                n_dones++;
                if (exp_done.size() == 0) chk("unexpected_done", 64'(rd_done_port_id), 64'hFFFF_FFFF);
                else begin
                    chk("done_port", 64'(rd_done_port_id), 64'(exp_done.pop_front()));
                    chk("done_with_last_free", 64'(frees_left[0]), 64'd0);
                    void'(frees_left.pop_front());
                end
            end
            if (stall_q) begin
                chk("hold_valid", 64'(em_tx_valid), 64'd1);
                chk("hold_data", 64'({em_tx_sop, em_tx_eop, em_tx_port_id, em_tx_data}), 64'(hold_val));
            end
            if (em_tx_valid) chk("tx_valid_expected", 64'(exp_beat.size() != 0), 64'd1);
            if (em_tx_valid && em_tx_ready && exp_beat.size() != 0) begin
                b = exp_beat.pop_front();
                n_beats++;
                chk("beat_sop",  64'(em_tx_sop),     64'(b.sop));
                chk("beat_eop",  64'(em_tx_eop),     64'(b.eop));
                chk("beat_port", 64'(em_tx_port_id), 64'(b.port));
                chk("beat_data", 64'(em_tx_data),    64'(b.data));
            end
            stall_q  = em_tx_valid && !em_tx_ready;
            hold_val = {em_tx_sop, em_tx_eop, em_tx_port_id, em_tx_data};
        end
    end

    task automatic model_packet(input logic [BW-1:0] p0, input int len,
                                input logic [IW-1:0] port, input logic disc);
        logic [BW-1:0] p;
        beat_t b;
        p = p0;
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(p);
            exp_free.push_back(p);
            if (!disc) begin
                b.sop  = (i == 0);
                b.eop  = (i == len - 1);
                b.port = port;
                b.data = mdata[p];
                exp_beat.push_back(b);
            end
            p = mnxt[p];
        end
        frees_left.push_back(len);
        exp_done.push_back(port);
    endtask

    // Presents a descriptor; returns 1ns after the accepting edge
    task automatic send(input logic [BW-1:0] p, input int len,
                        input logic [IW-1:0] port, input logic disc);
        int w;
        w = 0;
        @(negedge clk);
        while (!rd_req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rd_req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
        end else begin
            model_packet(p, len, port, disc);
            rd_req_valid   = 1'b1;
            rd_req_buf_ptr = p;
            rd_req_len     = LW'(len);
            rd_req_port_id = port;
            rd_req_discard = disc;
            @(posedge clk);
            #1;
            rd_req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (w < 1000 && (exp_rd.size() != 0 || exp_free.size() != 0 ||
                            exp_beat.size() != 0 || exp_done.size() != 0)) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 64'(w < 1000), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, d0, b0, w;
        int rc[$];
        int rp[$];
        int dcyc;

        rst = 1'b1;
        rd_req_valid = 1'b0;
        rd_req_buf_ptr = '0;
        rd_req_len = '0;
        rd_req_port_id = '0;
        rd_req_discard = 1'b0;
        mem_rd_data = '0;
        mem_rd_nxt_ptr = '0;
        em_tx_ready = 1'b1;
        stall_q = 1'b0;
        hold_val = '0;
        for (int i = 0; i < int'(MEM_N); i++) begin
            mdata[i] = DW'($urandom);
            mnxt[i]  = BW'($urandom);
        end

        // Reset state
        @(negedge clk);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_tx_valid",  64'(em_tx_valid), 64'd0);
        chk("rst_free",      64'(em_buf_free_valid), 64'd0);
        chk("rst_done",      64'(rd_done_valid), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(rd_req_ready), 64'd1);

        // Single chunk, exact latency
        rdy_mode = 1;
        mdata[5] = DW'(32'hA5);
        send(BW'(5), 1, IW'(2), 1'b0);
        @(negedge clk);
        chk("t1_c1_rd_en",  64'(mem_rd_en), 64'd1);
        chk("t1_c1_rd_ptr", 64'(mem_rd_ptr), 64'd5);
        @(negedge clk);
        chk("t1_c2_rd_en",  64'(mem_rd_en), 64'd0);
        chk("t1_c2_valid",  64'(em_tx_valid), 64'd0);
        chk("t1_c2_free",   64'(em_buf_free_valid), 64'd0);
        @(negedge clk);
        chk("t1_c3_valid",  64'(em_tx_valid), 64'd1);
        chk("t1_c3_sop",    64'(em_tx_sop), 64'd1);
        chk("t1_c3_eop",    64'(em_tx_eop), 64'd1);
        chk("t1_c3_data",   64'(em_tx_data), 64'hA5);
        chk("t1_c3_free",   64'(em_buf_free_valid), 64'd1);
        chk("t1_c3_fptr",   64'(em_buf_free_ptr), 64'd5);
        chk("t1_c3_done",   64'(rd_done_valid), 64'd1);
        chk("t1_c3_dport",  64'(rd_done_port_id), 64'd2);
        chk("t1_c3_ready",  64'(rd_req_ready), 64'd1);
        wait_idle();

        // Linked list 2->7->9, reads two cycles apart
        mnxt[2] = BW'(7);
        mnxt[7] = BW'(9);
        send(BW'(2), 3, IW'(1), 1'b0);
        dcyc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_rd_en) begin
                rc.push_back(k);
                rp.push_back(int'(mem_rd_ptr));
            end
            if (rd_done_valid) dcyc = k;
        end
        chk("t2_nreads", 64'(rc.size()), 64'd3);
        chk("t2_rd0", 64'(rp[0]), 64'd2);
        chk("t2_rd1", 64'(rp[1]), 64'd7);
        chk("t2_rd2", 64'(rp[2]), 64'd9);
        chk("t2_cyc0", 64'(rc[0]), 64'd1);
        chk("t2_cyc1", 64'(rc[1]), 64'd3);
        chk("t2_cyc2", 64'(rc[2]), 64'd5);
        chk("t2_done_cyc", 64'(dcyc), 64'd7);
        wait_idle();

        // Full backpressure: credit stops reads at FIFO depth
        rdy_mode = 0;
        r0 = n_reads; d0 = n_dones; b0 = n_beats;
        send(BW'(100), 4, IW'(4), 1'b0);
        repeat (30) @(negedge clk);
        chk("t3_reads", 64'(n_reads - r0), 64'd4);
        chk("t3_done",  64'(n_dones - d0), 64'd1);
        chk("t3_valid", 64'(em_tx_valid), 64'd1);
        chk("t3_nobeat", 64'(n_beats - b0), 64'd0);
        rdy_mode = 1;
        wait_idle();
        chk("t3_beats", 64'(n_beats - b0), 64'd4);

        // Discard while stalled: no stream, all buffers freed
        rdy_mode = 0;
        r0 = n_reads; f0 = n_frees; d0 = n_dones;
        send(BW'(200), 3, IW'(7), 1'b1);
        wait_idle();
        chk("t4_reads", 64'(n_reads - r0), 64'd3);
        chk("t4_frees", 64'(n_frees - f0), 64'd3);
        chk("t4_done",  64'(n_dones - d0), 64'd1);
        chk("t4_valid", 64'(em_tx_valid), 64'd0);
        rdy_mode = 1;

        // Zero-length descriptor
        send(BW'(11), 0, IW'(3), 1'b0);
        @(negedge clk);
        chk("t5_done",  64'(rd_done_valid), 64'd1);
        chk("t5_port",  64'(rd_done_port_id), 64'd3);
        chk("t5_rd_en", 64'(mem_rd_en), 64'd0);
        chk("t5_free",  64'(em_buf_free_valid), 64'd0);
        chk("t5_ready", 64'(rd_req_ready), 64'd1);
        send(BW'(12), 1, IW'(8), 1'b0);
        wait_idle();

        // Reset in WAIT of chunk 2 of 4
        r0 = n_reads;
        send(BW'(40), 4, IW'(5), 1'b0);
        w = 0;
        while (n_reads < r0 + 2 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t6_reach_chunk2", 64'(n_reads - r0), 64'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rd_en", 64'(mem_rd_en), 64'd0);
        chk("t6_valid", 64'(em_tx_valid), 64'd0);
        chk("t6_free",  64'(em_buf_free_valid), 64'd0);
        chk("t6_done",  64'(rd_done_valid), 64'd0);
        exp_rd.delete(); exp_free.delete(); exp_beat.delete();
        exp_done.delete(); frees_left.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        d0 = n_dones; f0 = n_frees;
        repeat (6) @(negedge clk);
        chk("t6_no_done", 64'(n_dones - d0), 64'd0);
        chk("t6_no_free", 64'(n_frees - f0), 64'd0);
        chk("t6_empty",   64'(em_tx_valid), 64'd0);
        d0 = n_dones;
        send(BW'(60), 1, IW'(6), 1'b0);
        wait_idle();
        chk("t6_after_done", 64'(n_dones - d0), 64'd1);

        // Randomized descriptor stream with random backpressure
        rdy_mode = 2;
        for (int n = 0; n < 60; n++) begin
            send(BW'($urandom), $urandom_range(0, 6), IW'($urandom), ($urandom_range(0, 3) == 0));
        end
        wait_idle();
        chk("end_rd_q",   64'(exp_rd.size()), 64'd0);
        chk("end_beat_q", 64'(exp_beat.size()), 64'd0);
        chk("end_done_q", 64'(exp_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edit_mem_read_data.md
Name: edit_mem_read_data

Overview:
Read-side counterpart of the edit-memory write path. Accepts one packet descriptor at a time: first buffer pointer, chunk count, PU id and discard flag.
- Walks the buffer linked list in edit memory, one chunk per two cycles.
- Streams chunk data downstream with sop/eop under valid/ready backpressure.
- Returns every visited buffer to the free pool and reports packet completion.

Parameters:
BPTR_NBITS, `EM_BUF_PTR_NBITS, buffer pointer width
ID_NBITS, `PU_ID_NBITS, PU/port id width
DATA_NBITS, `DATA_PATH_NBITS, chunk data width
LEN_NBITS, `PD_CHUNK_NBITS, packet length in chunks
OUT_FIFO_DEPTH_NBITS, 2, log2 of output FIFO depth (4 entries)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
rd_req_valid  in  1  descriptor valid
rd_req_ready  out  1  block can accept a descriptor
rd_req_buf_ptr  in  BPTR_NBITS  first buffer of packet
rd_req_len  in  LEN_NBITS  chunk count; 0 = nothing stored
rd_req_port_id  in  ID_NBITS  PU id carried to outputs
rd_req_discard  in  1  free buffers without emitting data
mem_rd_en  out  1  edit-memory read strobe
mem_rd_ptr  out  BPTR_NBITS  buffer to read
mem_rd_data  in  DATA_NBITS  chunk data, 1 cycle after strobe
mem_rd_nxt_ptr  in  BPTR_NBITS  link field, 1 cycle after strobe
em_tx_valid  out  1  output chunk valid
em_tx_ready  in  1  downstream accepts chunk
em_tx_sop  out  1  first chunk of packet
em_tx_eop  out  1  last chunk of packet
em_tx_data  out  DATA_NBITS  chunk data
em_tx_port_id  out  ID_NBITS  PU id of chunk
em_buf_free_valid  out  1  buffer returned to free pool
em_buf_free_ptr  out  BPTR_NBITS  returned buffer
rd_done_valid  out  1  packet finished (one pulse per descriptor)
rd_done_port_id  out  ID_NBITS  PU id of finished packet

Behaviour:
Reset:
- Asserting rst forces: state IDLE, output FIFO empty; mem_rd_en, em_buf_free_valid, rd_done_valid, em_tx_valid all 0.
- All pointer, data and id registers reset to 0.
- rd_req_ready is 1 one cycle after reset deasserts.
- Reset mid-packet abandons the packet: no done pulse, unvisited buffers are not freed. Buffer-pool reinit is the pool's responsibility.

FSM states IDLE, RD, WAIT:
- rd_req_ready = (state==IDLE), combinational.
- Request accept (IDLE, valid&ready): latch cur_ptr, remaining=len, port, discard; set first=1.
  - len!=0: go to RD.
  - len==0: stay IDLE; rd_done_valid=1 the next cycle; no memory read, no free.
- RD: issue only if discard=1, or FIFO count < 2^OUT_FIFO_DEPTH_NBITS.
  - Issue: mem_rd_en=1 for exactly one cycle (combinational strobe), mem_rd_ptr=cur_ptr; go to WAIT.
  - Otherwise hold in RD with mem_rd_en=0.
- WAIT: mem_rd_data and mem_rd_nxt_ptr are sampled this cycle.
  - If discard=0: push {sop=first, eop=(remaining==1), port, data} into the FIFO.
  - Register free: em_buf_free_valid=1 and em_buf_free_ptr=cur_ptr on the next cycle.
  - cur_ptr<=mem_rd_nxt_ptr; remaining<=remaining-1; first<=0.
  - remaining==1: go to IDLE; rd_done_valid=1 and rd_done_port_id=port on the next cycle (same cycle as the last free).
  - Otherwise go to RD.
- At most one read in flight. The FIFO push lands before the next RD evaluation, so the count-based credit cannot overflow.
- mem_rd_nxt_ptr of the last chunk is ignored.

Throughput and latency:
- Throughput: one chunk per 2 cycles.
- Single chunk, no backpressure: accept at cycle 0, mem_rd_en at cycle 1, push at end of cycle 2.
- em_tx_valid, free and done all at cycle 3.
- A new descriptor is accepted at cycle 3 at the earliest.

Output stream:
- Driven directly from a first-word-fall-through FIFO: em_tx_valid = ~empty; pop on em_tx_valid&em_tx_ready.
- Simultaneous push and pop keeps the count.
- Data held stable while valid&~ready.
- Backpressure stalls only the RD state; frees and done are not stalled.
- Discarded packets never touch the FIFO and never stall on credit.

Arithmetic:
- remaining is a LEN_NBITS down-counter and never wraps; it is only decremented when non-zero.

Decomposition:
- Shared package/defines: EM_BUF_PTR_NBITS, PU_ID_NBITS, DATA_PATH_NBITS, PD_CHUNK_NBITS.
- FSM state enum and the output FIFO entry struct {sop, eop, port_id, data} also go in the package.
- One sub-module: the existing sfifo2f_fo, width 2+ID_NBITS+DATA_NBITS, depth OUT_FIFO_DEPTH_NBITS.

Test Plan:
1. ptr=5, len=1, discard=0, ready=1, mem returns data=0xA5 -> cycle 1: mem_rd_ptr=5; cycle 3: one beat sop=1, eop=1, data=0xA5, free ptr=5, done.
2. ptr=2, len=3, links 2->7->9 -> reads 2,7,9 two cycles apart; beats sop/-/eop in order; frees 2,7,9; one done after the last free.
3. len=4, em_tx_ready=0 throughout -> exactly 4 reads, FIFO count 4, no further strobes; raise ready -> 4 beats drain; done fires without waiting for ready.
4. len=3, discard=1, em_tx_ready=0 -> 3 reads, 3 frees, done; em_tx_valid never asserted.
5. len=0, port=3 -> no mem_rd_en, no free; rd_done_valid next cycle with port_id=3; next descriptor accepted the cycle after.
6. rst asserted in WAIT of chunk 2 of 4 -> all outputs 0 asynchronously, FIFO empty, no done; a new len=1 request completes normally afterward.
